// File: rtl/efuse_macro_rsp_if.sv
// eFuse macro pin bundle: the controller drives strobes/address, the macro returns read data.
interface efuse_macro_rsp_if;
    logic       efuse_pgmen;
    logic       efuse_rden;
    logic       efuse_aen;
    logic [7:0] efuse_addr;
    logic [7:0] efuse_d;

    modport master (output efuse_pgmen, efuse_rden, efuse_aen, efuse_addr, input efuse_d);
    modport slave  (input efuse_pgmen, efuse_rden, efuse_aen, efuse_addr, output efuse_d);
endinterface

// File: rtl/efuse_macro_rsp.sv
// Behavioural-but-synthesizable responder for a 256-bit eFuse macro (32 bytes x 8 bits).
// Define EFUSE_RSP_TIMING_CHK_EN to enable program-width and low-gap timing checks.
module efuse_macro_rsp #(
    parameter int           MIN_TPGM = 8,
    parameter int           RD_LAT   = 2,
    parameter int           MIN_TLOW = 4,
    parameter logic [255:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    efuse_macro_rsp_if.slave bus,
    output logic [255:0]     fuse_bits,
    output logic [8:0]       blow_cnt,
    input  logic             err_clr,
    output logic             err_short_pgm,
    output logic             err_short_low,
    output logic             err_mode
);

`ifdef EFUSE_RSP_TIMING_CHK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RD_PULSE  = 2'd1;
    localparam logic [1:0] PGM_PULSE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    logic [1:0]   state, state_nxt;
    logic         aen_q;
    logic [9:0]   wcnt, lcnt;
    logic [7:0]   addr_q;
    logic [255:0] fuse_q;
    logic [7:0]   d_q;

    logic rise, fall, rd_mode, pg_mode, tpgm_ok;
    logic accept, rd_load, blow, set_mode, set_spgm, set_slow;
    logic [7:0] bit_idx;

    assign rise    = bus.efuse_aen & ~aen_q;
    assign fall    = ~bus.efuse_aen & aen_q;
    assign rd_mode = bus.efuse_rden & ~bus.efuse_pgmen;
    assign pg_mode = bus.efuse_pgmen & ~bus.efuse_rden;
    // Without timing checks any pulse that reached the fall (wcnt>=1) is long enough.
    assign tpgm_ok = !TCHK || (wcnt >= 10'(MIN_TPGM));
    assign bit_idx = {addr_q[4:0], addr_q[7:5]};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_load   = 1'b0;
        blow      = 1'b0;
        set_spgm  = 1'b0;
        set_slow  = 1'b0;
        set_mode  = (bus.efuse_pgmen & bus.efuse_rden) |
                    (bus.efuse_aen & ~bus.efuse_pgmen & ~bus.efuse_rden);
        case (state)
            IDLE, GAP: begin
                if (rise) begin
                    if (state == GAP && lcnt < 10'(MIN_TLOW)) set_slow = TCHK;
                    if (rd_mode) begin
                        state_nxt = RD_PULSE;
                        accept    = 1'b1;
                    end else if (pg_mode) begin
                        state_nxt = PGM_PULSE;
                        accept    = 1'b1;
                    end else begin
                        set_mode  = 1'b1;
                    end
                end else if (state == GAP && !bus.efuse_pgmen && !bus.efuse_rden) begin
                    state_nxt = IDLE;
                end
            end
            RD_PULSE: begin
                if (!rd_mode) set_mode = 1'b1;
                if (wcnt == 10'(RD_LAT)) rd_load = 1'b1;
                if (fall) state_nxt = GAP;
            end
            default: begin
                if (!pg_mode) set_mode = 1'b1;
                if (fall) begin
                    state_nxt = GAP;
                    if (!tpgm_ok) set_spgm = 1'b1;
                    else if (bus.efuse_pgmen) blow = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            aen_q    <= 1'b0;
            wcnt     <= '0;
            lcnt     <= '0;
            addr_q   <= '0;
            fuse_q   <= INIT_VAL;
            d_q      <= '0;
            blow_cnt <= '0;
        end else begin
            state <= state_nxt;
            aen_q <= bus.efuse_aen;
            if (bus.efuse_aen) begin
                wcnt <= rise ? 10'd1 : ((wcnt == 10'h3ff) ? wcnt : wcnt + 10'd1);
                lcnt <= '0;
            end else begin
                wcnt <= '0;
                lcnt <= fall ? 10'd1 : ((lcnt == 10'h3ff) ? lcnt : lcnt + 10'd1);
            end
            if (accept)  addr_q <= bus.efuse_addr;
            if (rd_load) d_q    <= fuse_q[{addr_q[4:0], 3'b000} +: 8];
            if (blow) begin
                fuse_q[bit_idx] <= 1'b1;
                if (!fuse_q[bit_idx]) blow_cnt <= blow_cnt + 9'd1;
            end
        end
    end

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_short_pgm <= 1'b0;
            err_short_low <= 1'b0;
            err_mode      <= 1'b0;
        end else begin
            err_short_pgm <= set_spgm | (err_short_pgm & ~err_clr);
            err_short_low <= set_slow | (err_short_low & ~err_clr);
            err_mode      <= set_mode | (err_mode & ~err_clr);
        end
    end

    assign bus.efuse_d = d_q;
    assign fuse_bits   = fuse_q;

endmodule

// File: tb/tb_efuse_macro_rsp.sv
// Directed + randomized bench for efuse_macro_rsp against a pulse-level reference model.
module tb_efuse_macro_rsp;
`ifdef EFUSE_RSP_TIMING_CHK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif
    localparam int MIN_TPGM = 8;
    localparam int MIN_TLOW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         err_clr = 1'b0;
    logic [255:0] fuse_bits;
    logic [8:0]   blow_cnt;
    logic         err_short_pgm, err_short_low, err_mode;

    efuse_macro_rsp_if bus();

    efuse_macro_rsp dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fuse_bits(fuse_bits), .blow_cnt(blow_cnt),
        .err_clr(err_clr), .err_short_pgm(err_short_pgm), .err_short_low(err_short_low),
        .err_mode(err_mode)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: byte array, blow count, sticky flags, last read byte.
    logic [7:0] mem [32];
    int         m_blow;
    bit         m_spgm, m_slow, m_mode;
    logic [7:0] m_d;
    bit         in_gap;
    int         last_lo;

    function automatic logic [255:0] model_bits();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = mem[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        m_blow = 0; m_spgm = 0; m_slow = 0; m_mode = 0; m_d = 8'h00;
        in_gap = 0; last_lo = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".d"},    256'(bus.efuse_d), 256'(m_d));
        chk({tag, ".bits"}, fuse_bits, model_bits());
        chk({tag, ".cnt"},  256'(blow_cnt), 256'(m_blow));
        chk({tag, ".spgm"}, 256'(err_short_pgm), 256'(m_spgm));
        chk({tag, ".slow"}, 256'(err_short_low), 256'(m_slow));
        chk({tag, ".mode"}, 256'(err_mode), 256'(m_mode));
    endtask

    // One clean access: enables held through the following low gap.
    task automatic pulse(input bit is_pgm, input logic [7:0] a, input int hi, input int lo);
        if (TCHK && in_gap && last_lo < MIN_TLOW) m_slow = 1;
        bus.efuse_pgmen = is_pgm;
        bus.efuse_rden  = !is_pgm;
        bus.efuse_addr  = a;
        bus.efuse_aen   = 1'b1;
        step(hi);
        bus.efuse_aen   = 1'b0;
        step(lo);
        if (is_pgm) begin
            if (!TCHK || hi >= MIN_TPGM) begin
                if (!mem[a[4:0]][a[7:5]]) m_blow++;
                mem[a[4:0]][a[7:5]] = 1'b1;
            end else begin
                m_spgm = 1;
            end
        end else begin
            m_d = mem[a[4:0]];
        end
        in_gap  = 1;
        last_lo = lo;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
        m_spgm = 0; m_slow = 0; m_mode = 0;
        last_lo += 2;
    endtask

    task automatic go_idle();
        bus.efuse_pgmen = 1'b0;
        bus.efuse_rden  = 1'b0;
        step(4);
        in_gap = 0;
    endtask

    initial begin
        bus.efuse_pgmen = 1'b0;
        bus.efuse_rden  = 1'b0;
        bus.efuse_aen   = 1'b0;
        bus.efuse_addr  = 8'h00;
        model_reset();
        step(3);
        rst_n = 1'b1;
        step(2);
        check_all("reset");

        for (int b = 0; b < 32; b++) begin
            pulse(1'b0, 8'(b), 8, 10);
            chk("rd_init", 256'(bus.efuse_d), 256'(mem[b]));
        end
        check_all("rd_all");

        pulse(1'b1, 8'h68, 20, 10);
        pulse(1'b0, 8'h08, 8, 10);
        chk("byte8", 256'(bus.efuse_d), 256'(8'h08));
        chk("bit67", 256'(fuse_bits[67]), 256'(1'b1));
        chk("cnt1",  256'(blow_cnt), 256'(9'd1));
        check_all("pgm68");

        pulse(1'b1, 8'h68, 20, 10);
        check_all("reblow");

        pulse(1'b1, 8'h01, 5, 10);
        check_all("short_pgm");
        clear_errs();
        check_all("clr1");

        pulse(1'b0, 8'h00, 8, 2);
        pulse(1'b0, 8'h08, 8, 10);
        check_all("short_low");
        clear_errs();

        bus.efuse_pgmen = 1'b1;
        bus.efuse_rden  = 1'b1;
        bus.efuse_addr  = 8'h00;
        bus.efuse_aen   = 1'b1;
        step(10);
        bus.efuse_aen   = 1'b0;
        step(10);
        m_mode = 1;
        go_idle();
        check_all("both_en");
        clear_errs();

        // pgmen drops while aen is still high: flags err_mode, blows nothing.
        bus.efuse_pgmen = 1'b1;
        bus.efuse_addr  = 8'h22;
        bus.efuse_aen   = 1'b1;
        step(10);
        bus.efuse_pgmen = 1'b0;
        step(2);
        bus.efuse_aen   = 1'b0;
        step(10);
        m_mode = 1;
        in_gap = 0;
        check_all("pgm_drop");
        clear_errs();
        check_all("clr2");

        for (int i = 0; i < 60; i++) begin
            bit         is_pgm;
            logic [7:0] a;
            is_pgm = 1'($urandom_range(0, 1));
            a      = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3))};
            pulse(is_pgm, a, is_pgm ? int'($urandom_range(3, 14)) : int'($urandom_range(3, 10)),
                  int'($urandom_range(1, 9)));
            check_all("rand");
            if ($urandom_range(0, 4) == 0) begin
                clear_errs();
                check_all("rand_clr");
            end
        end

        bus.efuse_pgmen = 1'b1;
        bus.efuse_rden  = 1'b0;
        bus.efuse_addr  = 8'hff;
        bus.efuse_aen   = 1'b1;
        step(12);
        rst_n = 1'b0;
        step(2);
        bus.efuse_aen   = 1'b0;
        bus.efuse_pgmen = 1'b0;
        step(1);
        rst_n = 1'b1;
        model_reset();
        step(2);
        check_all("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/efuse_macro_rsp.md
Name: efuse_macro_rsp

Overview:
- Synthesizable responder for the 256-bit eFuse macro interface (pgmen/rden/aen/addr/d), used for FPGA emulation and as the reference model in block-level simulation of the eFuse controller.
- Decodes read and program strobes, checks pulse timing, stores blown bits, and returns read bytes on efuse_d.
- Array is 32 bytes x 8 bits.
- Read address = byte index. Program address = {bit[2:0], byte[4:0]}.

Parameters:
- MIN_TPGM, 8: minimum aen-high cycles for a valid program pulse.
- RD_LAT, 2: aen-high cycles before efuse_d reflects the addressed byte.
- MIN_TLOW, 4: minimum aen-low cycles between pulses while pgmen or rden is active.
- INIT_VAL, 256'h0: array contents after reset (emulation preload).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- efuse_pgmen  in  1  program mode enable
- efuse_rden  in  1  read mode enable
- efuse_aen  in  1  access strobe
- efuse_addr  in  8  read: [4:0] byte; program: [7:5] bit, [4:0] byte
- efuse_d  out  8  read data byte
- fuse_bits  out  256  backdoor view of array, bit index = byte*8+bit
- blow_cnt  out  9  number of 0->1 bit transitions since reset
- err_clr  in  1  clears sticky error flags
- err_short_pgm  out  1  sticky: program pulse shorter than MIN_TPGM
- err_short_low  out  1  sticky: aen low gap shorter than MIN_TLOW
- err_mode  out  1  sticky: pgmen&rden both high, or aen high with neither enabled

Behaviour:
- Clock/reset: one clock clk; asynchronous active-low reset rst_n.
- Reset values: array=INIT_VAL, efuse_d=0, blow_cnt=0, all err flags=0, state=IDLE, wcnt=0, lcnt=0.
- Input sampling: all inputs sampled on posedge clk. aen rise/fall detected against a registered aen_q.
- Counters:
  - wcnt (10b, saturating at 1023) counts cycles aen is sampled high in the current pulse. The first high cycle has wcnt=1.
  - lcnt (10b, saturating) counts low cycles since the last fall.
- FSM states: IDLE, RD_PULSE, PGM_PULSE, GAP.
- IDLE:
  - aen rise with rden&~pgmen -> RD_PULSE.
  - aen rise with pgmen&~rden -> PGM_PULSE.
  - On either rise, latch addr into addr_q.
  - Any other aen rise sets err_mode and stays IDLE (no access).
- RD_PULSE:
  - When wcnt==RD_LAT, load efuse_d <= array byte addr_q[4:0], visible the next cycle.
  - efuse_d holds until the next read load.
  - aen fall -> GAP.
- PGM_PULSE:
  - On aen fall: if wcnt>=MIN_TPGM and pgmen still 1, set bit addr_q[4:0]*8+addr_q[7:5].
  - blow_cnt increments only if that bit was 0. Re-blowing a 1 is a no-op.
  - If wcnt<MIN_TPGM, set err_short_pgm and do not blow.
  - -> GAP.
- GAP:
  - aen rise with lcnt<MIN_TLOW: set err_short_low, but still accept the access (go to RD_PULSE/PGM_PULSE as in IDLE).
  - pgmen=0 and rden=0 -> IDLE.
- Mode changes mid-pulse:
  - pgmen/rden change during a pulse sets err_mode.
  - A program pulse whose pgmen drops before the fall does not blow.
- Other error/clear rules:
  - pgmen&rden high simultaneously in any cycle sets err_mode.
  - err_clr clears all flags. Same-cycle set and clear: set wins.
- Reset mid-pulse: no bit blown; array returns to INIT_VAL (emulation only).
- Address bits [7:5] are ignored for reads.

Optional Feature:
- Macro: EFUSE_RSP_TIMING_CHK_EN.
- Defined: timing checks as above (MIN_TPGM, MIN_TLOW, err_short_pgm, err_short_low).
- Undefined: any program pulse of >=1 cycle blows its bit; err_short_pgm and err_short_low tied 0; err_mode still active.

Test Plan:
- Reset with INIT_VAL=0, then 32 byte reads (rden=1, aen high 8 cycles, low 10) -> efuse_d=8'h00 each; no errors.
- Program addr 8'h68 (bit3, byte8) with 20-cycle aen pulse, then read byte 8 -> efuse_d=8'h08, fuse_bits[67]=1, blow_cnt=1.
- Repeat the same program pulse -> blow_cnt stays 1, fuse_bits unchanged.
- Program pulse of 5 cycles (MIN_TPGM=8) -> err_short_pgm=1, bit not blown. Pulse err_clr -> flag 0.
- Two read pulses separated by 2 low cycles -> err_short_low=1; second read still returns the correct byte.
- pgmen&rden both high with aen pulse -> err_mode=1, no blow, efuse_d unchanged.
- Assert rst_n low mid program pulse -> array=INIT_VAL, blow_cnt=0.
